// File: rtl/pipe_stage_skid_pkg.sv
// pipe_pkg: shared occupancy width and stall/flush priority for pipeline stages
package pipe_pkg;
    localparam int OCC_W = 2;
    localparam bit FLUSH_OVER_STALL = 1'b1;
    typedef logic [OCC_W-1:0] occ_t;
    function automatic occ_t occ_count(input logic a, input logic b);
        return {1'b0, a} + {1'b0, b};
    endfunction
endpackage

// File: rtl/pipe_stage_skid_if.sv
// pipe_stage_skid_if: handshake, payload and pipeline-control bundle for a skid stage
interface pipe_stage_skid_if #(parameter int DATA_W = 110) ();
    import pipe_pkg::*;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_sync;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              stall;
    logic              flush;
    logic              squash_req;
    logic              squashing;
    occ_t              occupancy;
    modport master (
        output in_valid, in_data, in_sync, out_ready, stall, flush, squash_req,
        input  in_ready, out_valid, out_data, squashing, occupancy
    );
    modport slave (
        input  in_valid, in_data, in_sync, out_ready, stall, flush, squash_req,
        output in_ready, out_valid, out_data, squashing, occupancy
    );
endinterface

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: two-entry skid stage with stall, flush and squash-until-sync
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W     = 110,
    parameter bit SQUASH_EN  = 1'b1,
    parameter bit RESET_DATA = 1'b1
) (
    input logic               clk,
    input logic               rst,
    pipe_stage_skid_if.slave  p
);
    logic              main_v_q, main_v_d, skid_v_q, skid_v_d, sq_q, sq_d;
    logic [DATA_W-1:0] main_q, main_d, skid_q, skid_d;
    logic              accept, xfer, keep, hold, main_free;
    assign p.out_valid = main_v_q & ~p.stall;
    assign p.out_data  = main_q;
    assign p.in_ready  = ~skid_v_q & ~p.stall;
    assign p.squashing = sq_q;
    assign p.occupancy = occ_count(main_v_q, skid_v_q);
    assign accept      = p.in_valid & p.in_ready;
    assign xfer        = p.out_valid & p.out_ready;
    assign keep        = accept & ~sq_q;
    assign hold        = p.stall & ~(p.flush & FLUSH_OVER_STALL);
    assign main_free   = ~main_v_q | xfer;
    always_comb begin
        main_v_d = main_v_q;
        skid_v_d = skid_v_q;
        main_d   = main_q;
        skid_d   = skid_q;
        sq_d     = sq_q;
        if (p.flush) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (!hold) begin
            if (skid_v_q && xfer) begin
                main_d   = skid_q;
                skid_v_d = 1'b0;
            end else if (keep && main_free) begin
                main_d   = p.in_data;
                main_v_d = 1'b1;
            end else if (keep) begin
                skid_d   = p.in_data;
                skid_v_d = 1'b1;
            end else if (xfer) begin
                main_v_d = 1'b0;
            end
            sq_d = p.squash_req | (sq_q & ~(accept & p.in_sync));
        end
        if (!SQUASH_EN) sq_d = 1'b0;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
            sq_q     <= 1'b0;
        end else begin
            main_v_q <= main_v_d;
            skid_v_q <= skid_v_d;
            sq_q     <= sq_d;
        end
    end
    // payload may skip reset entirely; validity bits alone guard it
    if (RESET_DATA) begin : g_rst_data
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                main_q <= '0;
                skid_q <= '0;
            end else begin
                main_q <= main_d;
                skid_q <= skid_d;
            end
        end
    end else begin : g_free_data
        always_ff @(posedge clk) begin
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: scoreboard bench for the skid stage handshake, stall, flush, squash and reset
module tb_pipe_stage_skid;
    localparam int DW = 110;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_chk = 0;
    int n_err = 0;
    logic [DW-1:0] exp_q[$];
    pipe_stage_skid_if #(.DATA_W(DW)) bus ();
    pipe_stage_skid #(.DATA_W(DW), .SQUASH_EN(1'b1), .RESET_DATA(1'b1)) dut (
        .clk(clk),
        .rst(rst),
        .p  (bus)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic push(input logic [DW-1:0] d, input logic sync, input logic expect_out);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_sync  = sync;
        if (expect_out) exp_q.push_back(d);
        tick();
    endtask
    task automatic drain();
        for (int i = 0; i < 50 && exp_q.size() > 0; i++) tick();
        check("drain", 128'(exp_q.size()), 128'(0));
    endtask
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) check("unexpected_beat", 128'(bus.out_data), 128'(0) - 128'(1));
            else check("out_data", 128'(bus.out_data), 128'(exp_q.pop_front()));
        end
    end
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
    initial begin
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_sync = 1'b0; bus.out_ready = 1'b1;
        bus.stall = 1'b0; bus.flush = 1'b0; bus.squash_req = 1'b0;
        tick(); tick();
        check("rst_occ", 128'(bus.occupancy), 128'(0));
        check("rst_ov", 128'(bus.out_valid), 128'(0));
        check("rst_ir", 128'(bus.in_ready), 128'(1));
        check("rst_sq", 128'(bus.squashing), 128'(0));
        rst = 1'b0;
        tick();
        push(110'hA5, 1'b0, 1'b1);
        bus.in_valid = 1'b0;
        check("single_ov", 128'(bus.out_valid), 128'(1));
        check("single_data", 128'(bus.out_data), 128'hA5);
        tick();
        check("single_occ", 128'(bus.occupancy), 128'(0));
        bus.out_ready = 1'b0;
        push(110'h1, 1'b0, 1'b1);
        push(110'h2, 1'b0, 1'b1);
        bus.in_valid = 1'b0;
        check("full_occ", 128'(bus.occupancy), 128'(2));
        check("full_ir", 128'(bus.in_ready), 128'(0));
        bus.out_ready = 1'b1;
        tick(); tick();
        check("full_drained", 128'(bus.occupancy), 128'(0));
        bus.out_ready = 1'b0;
        push(110'h7, 1'b0, 1'b1);
        bus.in_data = 110'h8; bus.stall = 1'b1; bus.out_ready = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("stall_ov", 128'(bus.out_valid), 128'(0));
            check("stall_ir", 128'(bus.in_ready), 128'(0));
            check("stall_occ", 128'(bus.occupancy), 128'(1));
            tick();
        end
        bus.stall = 1'b0; bus.in_valid = 1'b0;
        tick();
        check("stall_release_occ", 128'(bus.occupancy), 128'(0));
        for (int i = 0; i < 10; i++) begin
            push(DW'(32'h100 + i), 1'b0, 1'b1);
            check("stream_ir", 128'(bus.in_ready), 128'(1));
            check("stream_occ", 128'(bus.occupancy), 128'(1));
        end
        bus.in_valid = 1'b0;
        tick();
        check("stream_end_occ", 128'(bus.occupancy), 128'(0));
        bus.squash_req = 1'b1;
        tick();
        bus.squash_req = 1'b0;
        check("squash_on", 128'(bus.squashing), 128'(1));
        push(110'h3, 1'b0, 1'b0);
        check("squash_ov", 128'(bus.out_valid), 128'(0));
        push(110'h4, 1'b0, 1'b0);
        check("squash_hold", 128'(bus.squashing), 128'(1));
        push(110'h5, 1'b1, 1'b0);
        check("squash_off", 128'(bus.squashing), 128'(0));
        check("squash_occ", 128'(bus.occupancy), 128'(0));
        push(110'h6, 1'b0, 1'b1);
        bus.in_valid = 1'b0;
        drain();
        bus.squash_req = 1'b1;
        tick();
        push(110'h9, 1'b1, 1'b0);
        check("squash_prio", 128'(bus.squashing), 128'(1));
        bus.squash_req = 1'b0;
        push(110'h9, 1'b1, 1'b0);
        bus.in_valid = 1'b0; bus.in_sync = 1'b0;
        check("sync_clear", 128'(bus.squashing), 128'(0));
        bus.squash_req = 1'b1;
        tick();
        bus.squash_req = 1'b0; bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flush_keeps_sq", 128'(bus.squashing), 128'(1));
        push(110'hA, 1'b1, 1'b0);
        bus.in_valid = 1'b0; bus.in_sync = 1'b0;
        bus.out_ready = 1'b0;
        push(110'h11, 1'b0, 1'b0);
        push(110'h12, 1'b0, 1'b0);
        check("pre_flush_occ", 128'(bus.occupancy), 128'(2));
        bus.in_data = 110'h13; bus.stall = 1'b1; bus.flush = 1'b1;
        tick();
        bus.stall = 1'b0; bus.flush = 1'b0; bus.in_valid = 1'b0;
        check("flush_occ", 128'(bus.occupancy), 128'(0));
        check("flush_ov", 128'(bus.out_valid), 128'(0));
        bus.flush = 1'b1;
        push(110'h14, 1'b0, 1'b0);
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        check("flush_accept_occ", 128'(bus.occupancy), 128'(0));
        tick();
        check("flush_nothing_out", 128'(bus.out_valid), 128'(0));
        bus.out_ready = 1'b0;
        push(110'h21, 1'b0, 1'b0);
        bus.squash_req = 1'b1;
        push(110'h22, 1'b0, 1'b0);
        bus.squash_req = 1'b0; bus.in_valid = 1'b0;
        check("pre_rst_occ", 128'(bus.occupancy), 128'(2));
        check("pre_rst_sq", 128'(bus.squashing), 128'(1));
        #2;
        rst = 1'b1;
        #1;
        check("async_ov", 128'(bus.out_valid), 128'(0));
        check("async_sq", 128'(bus.squashing), 128'(0));
        check("async_occ", 128'(bus.occupancy), 128'(0));
        check("async_ir", 128'(bus.in_ready), 128'(1));
        tick();
        rst = 1'b0; bus.out_ready = 1'b1;
        tick(); tick();
        check("post_rst_ov", 128'(bus.out_valid), 128'(0));
        drain();
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 SHALL have parameter DATA_W, default 110, payload width in bits.
REQ-002 SHALL have parameter SQUASH_EN, default 1, enables squash-until-sync mode.
REQ-003 SHALL have parameter RESET_DATA, default 1, resets payload registers to zero when 1.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  upstream beat present.
REQ-007 SHALL have port in_ready  output  1  stage accepts beat this cycle.
REQ-008 SHALL have port in_data  input  DATA_W  upstream payload.
REQ-009 SHALL have port in_sync  input  1  beat is a resync marker (control-transfer op).
REQ-010 SHALL have port out_valid  output  1  downstream beat present.
REQ-011 SHALL have port out_ready  input  1  downstream accepts.
REQ-012 SHALL have port out_data  output  DATA_W  downstream payload.
REQ-013 SHALL have port stall  input  1  global freeze (memory stall).
REQ-014 SHALL have port flush  input  1  discard all held beats.
REQ-015 SHALL have port squash_req  input  1  start dropping incoming beats until a sync beat.
REQ-016 SHALL have port squashing  output  1  squash mode active.
REQ-017 SHALL have port occupancy  output  2  held beats, 0..2.

Function
REQ-018 SHALL hold two entries: main (drives out_*) and skid; out_valid = main_v AND NOT stall; out_data = main payload.
REQ-019 SHALL drive in_ready = NOT skid_v AND NOT stall, from registered state only (no out_ready path).
REQ-020 SHALL define accept = in_valid AND in_ready; transfer = out_valid AND out_ready.
REQ-021 SHALL, while stall=1 and flush=0, hold all state unchanged.
REQ-022 SHALL write an accepted, non-dropped beat to main if main is empty or transferring this cycle with skid empty; otherwise to skid.
REQ-023 SHALL move skid to main on transfer when skid_v=1, in the same edge as any new accept landing in skid.
REQ-024 SHALL preserve strict FIFO order; empty-stage latency in->out is one cycle.
REQ-025 SHALL sustain one beat per cycle when out_ready=1 continuously.
REQ-026 SHALL, on flush=1, clear main_v and skid_v at the next edge regardless of stall; a beat accepted that cycle is discarded.
REQ-027 SHALL set squashing at the next edge when squash_req=1 and SQUASH_EN=1.
REQ-028 SHALL, while squashing=1, complete handshakes on accepted beats but discard them.
REQ-029 SHALL clear squashing on an accepted beat with in_sync=1; that sync beat is also discarded.
REQ-030 SHALL give squash_req priority over sync-clear in the same cycle (squashing stays 1).
REQ-031 SHALL leave squashing unchanged on flush.
REQ-032 SHALL tie squashing to 0 and ignore squash_req when SQUASH_EN=0.
REQ-033 SHALL report occupancy = main_v + skid_v.

Reset
REQ-034 SHALL, on rst=1, immediately clear main_v, skid_v, squashing; occupancy=0, out_valid=0, in_ready=1 (stall=0).
REQ-035 SHALL clear payload registers on reset only when RESET_DATA=1; otherwise payload is don't-care.
REQ-036 SHALL, on reset asserted mid-transfer, drop all held beats; no partial beat emitted after release.

Structure
REQ-037 SHALL place occupancy width constant and shared stall/flush priority constants in package pipe_pkg.
REQ-038 SHALL be a single module; no sub-module is needed.

Verification
REQ-039 SHALL test: empty, in_valid=1 data=0xA5 for 1 cycle, out_ready=1 -> out_valid=1 data=0xA5 next cycle, occupancy back to 0.
REQ-040 SHALL test: out_ready=0, push 0x1,0x2 -> occupancy=2, in_ready=0; out_ready=1 -> 0x1 then 0x2 on consecutive cycles.
REQ-041 SHALL test: occupancy=1, stall=1 for 3 cycles with in_valid=1 -> no accept, out_valid=0, state held; release -> original beat emitted first.
REQ-042 SHALL test: squash_req pulse, push 0x3,0x4, 0x5(sync), 0x6 -> only 0x6 emerges; squashing falls after 0x5.
REQ-043 SHALL test: occupancy=2, flush=1 with stall=1 and in_valid=1 -> occupancy=0 next edge, nothing emitted.
REQ-044 SHALL test: rst asserted asynchronously mid-stream -> out_valid=0, squashing=0 before next clk edge.
